data_stack: RTL and testbench
=============================

# data_stack

Parameterised LIFO data stack that executes the 3-bit stack operation code produced by the control decoder. It sits in the datapath between the stack-source mux (imm / lui / mem / ALU / input) and the ALU. It holds the operand stack and presents the top two entries as ALU operands A and B. It also reports depth and sticky fault status for the debug/IO path.

## Interface
- `WIDTH`, 16, data word width in bits
- `DEPTH`, 16, number of entries; power of two, ≥ 4
- `CLK`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clears the stack
- `stackOP`  in  3  operation code: 0 NONE, 1 PUSH, 2 POPANDREPLACE, 3 POP, 4 POP2, 5 SWAP; 6–7 act as NONE
- `wdata`  in  WIDTH  value for PUSH and POPANDREPLACE, already selected by the stack-source mux
- `top`  out  WIDTH  entry at depth−1 (ALU A); 0 when depth < 1
- `second`  out  WIDTH  entry at depth−2 (ALU B); 0 when depth < 2
- `depth`  out  $clog2(DEPTH)+1  current entry count
- `empty` / `full`  out  1  depth==0 / depth==DEPTH
- `overflow`  out  1  sticky; PUSH was attempted while full
- `underflow`  out  1  sticky; an op was attempted with too few entries

## Operation
- Storage is `mem[0..DEPTH-1]` plus count register `depth`. Entry `mem[depth-1]` is the top.
- PUSH: needs depth < DEPTH. Writes `mem[depth] <= wdata`, then depth+1.
- POP: needs depth ≥ 1. Sets depth−1. Memory is untouched; the popped value is consumed externally via `top` in the same cycle (for example by the memory-store path).
- POPANDREPLACE: needs depth ≥ 2. Writes `mem[depth-2] <= wdata`, then depth−1. This implements binary ALU ops: A op B replaces both operands.
- POP2: needs depth ≥ 2. Sets depth−2.
- SWAP: needs depth ≥ 2. Writes `mem[depth-1] <= old mem[depth-2]` and `mem[depth-2] <= old mem[depth-1]` in one edge.
- NONE / 6 / 7: no state change.
- Requirement not met: the op is ignored entirely (no memory write, no depth change) and the matching sticky flag is set. Overflow applies only to PUSH; underflow applies to all other ops.
- Sticky flags clear only on reset.
- Only one op is presented per cycle, so simultaneous ops cannot occur. `wdata` is ignored for all ops except PUSH and POPANDREPLACE.

## Timing
- All state updates on the rising edge of `CLK`. `top`, `second`, `empty` and `full` are combinational from registered state.
- Latency: the effect of an op sampled at edge N is visible on the outputs after edge N.
- `top` and `second` must be valid in the same cycle the op is presented, because the ALU result computed from them feeds `wdata` back through the stack-source mux (combinational loop-free: `wdata` never feeds `top`/`second` combinationally).
- Reset values: `depth`=0, `empty`=1, `full`=0, `top`=0, `second`=0, `overflow`=0, `underflow`=0.
- Reset has priority over any concurrent op. Memory contents are not cleared, but they are unobservable while depth is 0.
- Boundaries:
  - PUSH at depth DEPTH−1 gives `full`=1.
  - POP at depth 1 gives `empty`=1.
  - POP2 at depth 2 gives `empty`=1.
  - No pointer wrap-around is allowed under any op.

## Configuration
- `DATA_STACK_ERR_EN` defined: precondition checks as above. `overflow`/`underflow` are sticky registers, and illegal ops are suppressed.
- `DATA_STACK_ERR_EN` not defined:
  - No checks and no flag registers. `overflow` and `underflow` are tied to 0.
  - Out-of-range ops still execute; depth arithmetic wraps modulo 2^width(depth), and memory indices wrap modulo DEPTH.
  - Behaviour is then undefined architecturally and is used only for minimal-area builds.

## Structure
- `stack_pkg` holds:
  - Op encoding constants: NONE, PUSH, POPANDREPLACE, POP, POP2, SWAP.
  - The identical encoding for the return-stack op (2-bit subset: NONE, PUSH, POP).
- The control decoder and this block both import `stack_pkg`.
- No sub-module: the array and depth counter live in one module. The return stack is a second instance with `WIDTH`=16 and `stackOP` zero-extended.

## Test plan
- Reset, then PUSH 0x0005, PUSH 0x0003 → `depth`=2, `top`=0x0003, `second`=0x0005, `empty`=0.
- From that state, POPANDREPLACE with `wdata`=0x0008 → `depth`=1, `top`=0x0008, `second`=0.
- PUSH 0x1111, PUSH 0x2222, then SWAP → `top`=0x1111, `second`=0x2222, depth unchanged; POP2 → `empty`=1.
- DEPTH PUSHes of 0..15 → `full`=1, `top`=15. A 17th PUSH of 0xFFFF → `top` stays 15, depth stays 16, `overflow`=1 and stays 1 through later legal POPs.
- With depth 1: POPANDREPLACE, POP2 and SWAP each → no state change, `underflow`=1. POP from empty → `underflow` stays 1, `depth` stays 0.
- Push 3 entries, then assert `reset` with PUSH in the same cycle → `depth`=0, both flags 0, `top`=0 on the following cycle.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg
//   Shared stack operation encodings for the control decoder, the data
//   stack and the return stack.
//   - stack_op_e : 3-bit data stack operation code
//   - rs_op_e    : 2-bit return stack subset, same code values, so the
//                  return stack can reuse data_stack with stackOP
//                  zero-extended from 2 to 3 bits.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE          = 3'd0,
    OP_PUSH          = 3'd1,
    OP_POPANDREPLACE = 3'd2,
    OP_POP           = 3'd3,
    OP_POP2          = 3'd4,
    OP_SWAP          = 3'd5
  } stack_op_e;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_PUSH = 2'd1,
    RS_POP  = 2'd3
  } rs_op_e;

endpackage

// File: rtl/data_stack.sv
// data_stack
//   LIFO operand stack driven by a 3-bit op code. The top two entries are
//   presented combinationally as ALU operands (top = A, second = B).
//
// Ports
//   CLK        in   rising-edge clock
//   reset      in   synchronous active-high reset (clears depth and flags)
//   stackOP    in   op code (see stack_pkg::stack_op_e); 6-7 act as NONE
//   wdata      in   data for PUSH and POPANDREPLACE
//   top        out  mem[depth-1], 0 when depth < 1
//   second     out  mem[depth-2], 0 when depth < 2
//   depth      out  current entry count
//   empty/full out  depth == 0 / depth == DEPTH
//   overflow   out  sticky: PUSH attempted while full
//   underflow  out  sticky: op attempted with too few entries
//
// Build option
//   DATA_STACK_ERR_EN : when defined, illegal ops are suppressed and the
//   sticky flags are implemented. When undefined, no checks are made,
//   depth and indices simply wrap, and overflow/underflow are tied to 0.
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [2:0]               stackOP,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         top,
  output logic [WIDTH-1:0]         second,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [DW-1:0] D_TWO = DW'(2);
  localparam logic [DW-1:0] D_MAX = DW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [DW-1:0]    depth_m1, depth_m2;
  logic [AW-1:0]    idx_push, idx_top, idx_sec;
  logic             has_1, has_2;
  logic             ok_push, ok_1, ok_2;
  stack_op_e        op;

  assign op = stack_op_e'(stackOP);

  // Index arithmetic keeps only the low AW bits, so an unchecked build
  // wraps modulo DEPTH instead of indexing out of range.
  assign depth_m1 = depth_q - D_ONE;
  assign depth_m2 = depth_q - D_TWO;
  assign idx_push = depth_q[AW-1:0];
  assign idx_top  = depth_m1[AW-1:0];
  assign idx_sec  = depth_m2[AW-1:0];

  assign has_1 = (depth_q >= D_ONE);
  assign has_2 = (depth_q >= D_TWO);

  assign empty  = (depth_q == '0);
  assign full   = (depth_q == D_MAX);
  assign depth  = depth_q;

  // Operands come from registered state only, so the ALU -> wdata path
  // can never loop back into top/second.
  assign top    = has_1 ? mem_q[idx_top] : '0;
  assign second = has_2 ? mem_q[idx_sec] : '0;

`ifdef DATA_STACK_ERR_EN
  assign ok_push = ~full;
  assign ok_1    = has_1;
  assign ok_2    = has_2;
`else
  assign ok_push = 1'b1;
  assign ok_1    = 1'b1;
  assign ok_2    = 1'b1;
`endif

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    case (op)
      OP_PUSH: begin
        if (ok_push) begin
          mem_d[idx_push] = wdata;
          depth_d         = depth_q + D_ONE;
        end
      end
      OP_POPANDREPLACE: begin
        if (ok_2) begin
          mem_d[idx_sec] = wdata;
          depth_d        = depth_m1;
        end
      end
      OP_POP: begin
        if (ok_1) begin
          depth_d = depth_m1;
        end
      end
      OP_POP2: begin
        if (ok_2) begin
          depth_d = depth_m2;
        end
      end
      OP_SWAP: begin
        if (ok_2) begin
          mem_d[idx_top] = mem_q[idx_sec];
          mem_d[idx_sec] = mem_q[idx_top];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Storage is not cleared by reset; it is unreachable while depth is 0.
  // Writes are still blocked during reset so reset wins over the op.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

`ifdef DATA_STACK_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case (op)
      OP_PUSH: begin
        if (!ok_push) overflow_d = 1'b1;
      end
      OP_POP: begin
        if (!ok_1) underflow_d = 1'b1;
      end
      OP_POPANDREPLACE, OP_POP2, OP_SWAP: begin
        if (!ok_2) underflow_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_stack.sv
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             CLK;
  logic             reset;
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] top, second;
  logic [4:0]       depth;
  logic             empty, full, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DATA_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .stackOP(stackOP), .wdata(wdata),
    .top(top), .second(second), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] wd;
    int          d;
    logic [15:0] t;
    logic [15:0] s;
  } vec_t;

  // reference model
  logic [15:0] q[$];
  bit          m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int d, input logic [15:0] t,
                             input logic [15:0] s, input bit ovf, input bit unf);
    chk({tag, ".depth"},  32'(depth), 32'(d));
    chk({tag, ".top"},    32'(top), 32'(t));
    chk({tag, ".second"}, 32'(second), 32'(s));
    chk({tag, ".empty"},  32'(empty), 32'(d == 0));
    chk({tag, ".full"},   32'(full), 32'(d == DEPTH));
    chk({tag, ".ovf"},    32'(overflow), 32'(ovf));
    chk({tag, ".unf"},    32'(underflow), 32'(unf));
  endtask

  // Inputs are applied 1 time unit after a rising edge; results are
  // sampled 1 time unit after the next rising edge.
  task automatic step(input logic [2:0] op, input logic [15:0] wd);
    stackOP = op;
    wdata   = wd;
    @(posedge CLK);
    #1;
    stackOP = 3'd0;
    wdata   = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stackOP = 3'd0;
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  function automatic logic [15:0] m_top();
    return (q.size() >= 1) ? q[q.size()-1] : 16'h0;
  endfunction

  function automatic logic [15:0] m_sec();
    return (q.size() >= 2) ? q[q.size()-2] : 16'h0;
  endfunction

  function automatic bit m_legal(input logic [2:0] op);
    case (op)
      3'd1:       return q.size() < DEPTH;
      3'd3:       return q.size() >= 1;
      3'd2, 3'd4,
      3'd5:       return q.size() >= 2;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic m_apply(input logic [2:0] op, input logic [15:0] wd);
    logic [15:0] a, b;
    if (!m_legal(op)) begin
      if (op == 3'd1) m_ovf = 1'b1;
      else            m_unf = 1'b1;
    end else begin
      case (op)
        3'd1: q.push_back(wd);
        3'd2: begin void'(q.pop_back()); void'(q.pop_back()); q.push_back(wd); end
        3'd3: void'(q.pop_back());
        3'd4: begin void'(q.pop_back()); void'(q.pop_back()); end
        3'd5: begin a = q.pop_back(); b = q.pop_back(); q.push_back(a); q.push_back(b); end
        default: ;
      endcase
    end
  endtask

  vec_t vecs[$];

  initial begin
    reset   = 1'b1;
    stackOP = 3'd0;
    wdata   = '0;

    vecs.push_back('{3'd1, 16'h0005, 1, 16'h0005, 16'h0000});
    vecs.push_back('{3'd1, 16'h0003, 2, 16'h0003, 16'h0005});
    vecs.push_back('{3'd0, 16'hdead, 2, 16'h0003, 16'h0005});
    vecs.push_back('{3'd2, 16'h0008, 1, 16'h0008, 16'h0000});
    vecs.push_back('{3'd3, 16'hbeef, 0, 16'h0000, 16'h0000});
    vecs.push_back('{3'd1, 16'h1111, 1, 16'h1111, 16'h0000});
    vecs.push_back('{3'd1, 16'h2222, 2, 16'h2222, 16'h1111});
    vecs.push_back('{3'd5, 16'h7777, 2, 16'h1111, 16'h2222});
    vecs.push_back('{3'd6, 16'h9999, 2, 16'h1111, 16'h2222});
    vecs.push_back('{3'd7, 16'h4444, 2, 16'h1111, 16'h2222});
    vecs.push_back('{3'd4, 16'h5555, 0, 16'h0000, 16'h0000});

    do_reset();
    check_state("reset", 0, 16'h0, 16'h0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].wd);
      check_state($sformatf("vec%0d", i), vecs[i].d, vecs[i].t, vecs[i].s, 1'b0, 1'b0);
    end

    // fill to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      step(3'd1, 16'(i));
      check_state($sformatf("fill%0d", i), i + 1, 16'(i), (i == 0) ? 16'h0 : 16'(i - 1), 1'b0, 1'b0);
    end

    if (ERR_EN) begin
      step(3'd1, 16'hffff);
      check_state("ovf_push", 16, 16'd15, 16'd14, 1'b1, 1'b0);
      // drain to depth 1; overflow must stay set
      for (int i = 15; i >= 1; i--) begin
        step(3'd3, 16'h0);
        check_state($sformatf("drain%0d", i), i, 16'(i - 1), (i >= 2) ? 16'(i - 2) : 16'h0, 1'b1, 1'b0);
      end
      step(3'd2, 16'habcd);
      check_state("unf_par", 1, 16'h0, 16'h0, 1'b1, 1'b1);
      step(3'd4, 16'h0);
      check_state("unf_pop2", 1, 16'h0, 16'h0, 1'b1, 1'b1);
      step(3'd5, 16'h0);
      check_state("unf_swap", 1, 16'h0, 16'h0, 1'b1, 1'b1);
      step(3'd3, 16'h0);
      check_state("pop_last", 0, 16'h0, 16'h0, 1'b1, 1'b1);
      step(3'd3, 16'h0);
      check_state("unf_pop_empty", 0, 16'h0, 16'h0, 1'b1, 1'b1);
    end else begin
      step(3'd4, 16'h0);
      check_state("pop2_full", 14, 16'd13, 16'd12, 1'b0, 1'b0);
    end

    // reset with concurrent PUSH
    do_reset();
    step(3'd1, 16'h00a1);
    step(3'd1, 16'h00a2);
    step(3'd1, 16'h00a3);
    check_state("pre_rst", 3, 16'h00a3, 16'h00a2, 1'b0, 1'b0);
    reset = 1'b1;
    step(3'd1, 16'h0bad);
    reset = 1'b0;
    check_state("rst_push", 0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(3'd1, 16'h0042);
    check_state("post_rst", 1, 16'h0042, 16'h0, 1'b0, 1'b0);

    // randomized run against the queue model
    do_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  op;
      logic [15:0] wd;
      op = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      if (!ERR_EN && !m_legal(op)) op = 3'd0;
      m_apply(op, wd);
      step(op, wd);
      check_state($sformatf("rnd%0d", i), q.size(), m_top(), m_sec(), m_ovf, m_unf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
